// File: rtl/regfile_scoreboard_if.sv
// Issue/read/writeback bundle between decode-issue, WB and the register file scoreboard.
`timescale 1ns/1ps
interface regfile_scoreboard_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  logic [ADDR_W-1:0]   rd_addr_a;
  logic [ADDR_W-1:0]   rd_addr_b;
  logic [DATA_W-1:0]   rd_data_a;
  logic [DATA_W-1:0]   rd_data_b;
  logic                iss_valid;
  logic [ADDR_W-1:0]   iss_dst;
  logic                iss_use_a;
  logic                iss_use_b;
  logic                stall;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [NUM_REGS-1:0] busy_mask;
  logic                sb_err;

  modport master (
    output rd_addr_a, rd_addr_b, iss_valid, iss_dst, iss_use_a, iss_use_b,
           wr_en, wr_addr, wr_data,
    input  rd_data_a, rd_data_b, stall, busy_mask, sb_err
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, iss_valid, iss_dst, iss_use_a, iss_use_b,
           wr_en, wr_addr, wr_data,
    output rd_data_a, rd_data_b, stall, busy_mask, sb_err
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with per-register outstanding-write counters, RAW stall generation
// and optional writeback-to-read forwarding.
`timescale 1ns/1ps
module regfile_scoreboard #(
  parameter int DATA_W     = 32,
  parameter int NUM_REGS   = 32,
  parameter int PEND_W     = 2,
  parameter int INIT_INDEX = 1,
  parameter int BYPASS     = 1
) (
  input logic                 clk,
  input logic                 rst,
  regfile_scoreboard_if.slave bus
);
  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [PEND_W-1:0]   pend [NUM_REGS];
  logic                sb_err_q;
  logic                wr_live;
  logic                haz_a;
  logic                haz_b;
  logic                dst_full;
  logic                stall_c;
  logic                accept;
  logic [NUM_REGS-1:0] inc;
  logic [NUM_REGS-1:0] dec;

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    if (addr == '0)
      return '0;
    else if ((BYPASS != 0) && bus.wr_en && (bus.wr_addr == addr))
      return bus.wr_data;
    else
      return regs[addr];
  endfunction

  // A single pending write being retired this very cycle is covered by forwarding.
  function automatic logic hazard(input logic use_src, input logic [ADDR_W-1:0] addr);
    logic fwd;
    fwd = (BYPASS != 0) && (pend[addr] == PEND_W'(1)) && bus.wr_en && (bus.wr_addr == addr);
    return use_src && (addr != '0) && (pend[addr] != '0) && !fwd;
  endfunction

  always_comb begin
    wr_live  = bus.wr_en && (bus.wr_addr != '0);
    haz_a    = hazard(bus.iss_use_a, bus.rd_addr_a);
    haz_b    = hazard(bus.iss_use_b, bus.rd_addr_b);
    dst_full = (bus.iss_dst != '0) && (pend[bus.iss_dst] == PEND_MAX);
    stall_c  = bus.iss_valid && (haz_a || haz_b || dst_full);
    accept   = bus.iss_valid && !stall_c;
    inc = '0;
    dec = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      inc[i] = accept && (bus.iss_dst == ADDR_W'(i));
      dec[i] = wr_live && (bus.wr_addr == ADDR_W'(i));
    end
    bus.rd_data_a = read_port(bus.rd_addr_a);
    bus.rd_data_b = read_port(bus.rd_addr_b);
    bus.stall     = stall_c;
    bus.sb_err    = sb_err_q;
    bus.busy_mask = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      bus.busy_mask[i] = (pend[i] != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= (INIT_INDEX != 0) ? DATA_W'(i) : '0;
        pend[i] <= '0;
      end
      sb_err_q <= 1'b0;
    end else begin
      if (wr_live) begin
        regs[bus.wr_addr] <= bus.wr_data;
        // Retiring a write nobody issued is flagged even if an issue lands on it the same cycle.
        if (pend[bus.wr_addr] == '0)
          sb_err_q <= 1'b1;
      end
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        if (inc[i] && !dec[i])
          pend[i] <= pend[i] + 1'b1;
        else if (dec[i] && !inc[i] && (pend[i] != '0))
          pend[i] <= pend[i] - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed plus randomized bench for regfile_scoreboard against an array/counter model.
`timescale 1ns/1ps
module tb_regfile_scoreboard;
  localparam int DW = 32;
  localparam int NR = 32;
  localparam int PMAX = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_scoreboard_if #(.DATA_W(DW), .NUM_REGS(NR)) bus ();

  regfile_scoreboard #(
    .DATA_W(DW), .NUM_REGS(NR), .PEND_W(2), .INIT_INDEX(1), .BYPASS(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int compared = 0;
  int mismatched = 0;

  logic [DW-1:0] m_reg [NR];
  int            m_pend [NR];
  bit            m_err;

  function automatic logic [DW-1:0] exp_rd(input int addr);
    if (addr == 0) return '0;
    if (bus.wr_en && int'(bus.wr_addr) == addr) return bus.wr_data;
    return m_reg[addr];
  endfunction

  function automatic bit exp_haz(input bit use_src, input int addr);
    if (!use_src || addr == 0 || m_pend[addr] == 0) return 1'b0;
    if (m_pend[addr] == 1 && bus.wr_en && int'(bus.wr_addr) == addr) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit exp_stall();
    int d;
    d = int'(bus.iss_dst);
    return bus.iss_valid && (exp_haz(bus.iss_use_a, int'(bus.rd_addr_a)) ||
                             exp_haz(bus.iss_use_b, int'(bus.rd_addr_b)) ||
                             (d != 0 && m_pend[d] == PMAX));
  endfunction

  function automatic logic [NR-1:0] exp_busy();
    logic [NR-1:0] m;
    m = '0;
    for (int i = 0; i < NR; i++) m[i] = (m_pend[i] != 0);
    return m;
  endfunction

  function automatic int next_pend(input int i);
    bit inc, dec;
    inc = bus.iss_valid && !exp_stall() && int'(bus.iss_dst) == i;
    dec = bus.wr_en && int'(bus.wr_addr) == i;
    if (inc && !dec) return m_pend[i] + 1;
    if (dec && !inc) return (m_pend[i] > 0) ? m_pend[i] - 1 : 0;
    return m_pend[i];
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NR; i++) begin
        m_reg[i]  <= DW'(i);
        m_pend[i] <= 0;
      end
      m_err <= 1'b0;
    end else begin
      for (int i = 1; i < NR; i++) m_pend[i] <= next_pend(i);
      if (bus.wr_en && bus.wr_addr != '0) begin
        m_reg[bus.wr_addr] <= bus.wr_data;
        if (m_pend[bus.wr_addr] == 0) m_err <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_compare();
    chk("rd_data_a", bus.rd_data_a, exp_rd(int'(bus.rd_addr_a)));
    chk("rd_data_b", bus.rd_data_b, exp_rd(int'(bus.rd_addr_b)));
    chk("stall", DW'(bus.stall), DW'(exp_stall()));
    chk("busy_mask", bus.busy_mask, exp_busy());
    chk("sb_err", DW'(bus.sb_err), DW'(m_err));
  endtask

  task automatic at_neg();
    @(negedge clk);
    model_compare();
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rd_addr_a = '0; bus.rd_addr_b = '0;
    bus.iss_valid = 1'b0; bus.iss_dst = '0;
    bus.iss_use_a = 1'b0; bus.iss_use_b = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
  endtask

  task automatic issue(input int dst);
    idle();
    bus.iss_valid = 1'b1; bus.iss_dst = 5'(dst);
    at_neg(); next();
  endtask

  task automatic wback(input int addr, input logic [DW-1:0] data);
    idle();
    bus.wr_en = 1'b1; bus.wr_addr = 5'(addr); bus.wr_data = data;
    at_neg(); next();
  endtask

  initial begin
    idle();
    bus.rd_addr_a = 5'd5; bus.rd_addr_b = 5'd31;
    #1 rst = 1'b0;
    #2;
    chk("rst_rd_a", bus.rd_data_a, 32'd5);
    chk("rst_rd_b", bus.rd_data_b, 32'd31);
    chk("rst_busy", bus.busy_mask, 32'd0);
    chk("rst_stall", DW'(bus.stall), 32'd0);
    at_neg();
    #2 rst = 1'b1;
    next();
    at_neg();
    chk("rel_rd_a", bus.rd_data_a, 32'd5);
    chk("rel_sb_err", DW'(bus.sb_err), 32'd0);
    next();

    // RAW on R3 with forwarding on the retiring writeback
    issue(3);
    idle();
    bus.iss_valid = 1'b1; bus.iss_use_a = 1'b1; bus.rd_addr_a = 5'd3;
    at_neg(); chk("raw_stall1", DW'(bus.stall), 32'd1); next();
    at_neg(); chk("raw_stall2", DW'(bus.stall), 32'd1); next();
    bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'h0000_0003;
    at_neg();
    chk("fwd_stall", DW'(bus.stall), 32'd0);
    chk("fwd_rd_a", bus.rd_data_a, 32'd3);
    next();
    idle();
    at_neg(); chk("r3_idle", DW'(bus.busy_mask[3]), 32'd0); next();

    // R0 writes and issues leave everything untouched
    idle();
    bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'h0000_FFFF;
    at_neg(); chk("r0_rd", bus.rd_data_a, 32'd0); chk("r0_busy", bus.busy_mask, 32'd0); next();
    issue(0);
    idle();
    at_neg(); chk("r0_iss_busy", bus.busy_mask, 32'd0); next();

    // Simultaneous increment and decrement on R4
    issue(4);
    idle();
    bus.iss_valid = 1'b1; bus.iss_dst = 5'd4;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd4; bus.wr_data = 32'h44;
    at_neg(); chk("r4_stall", DW'(bus.stall), 32'd0); next();
    idle();
    at_neg(); chk("r4_busy", DW'(bus.busy_mask[4]), 32'd1); next();
    wback(4, 32'h45);

    // Saturation on R6, then an unmatched writeback
    issue(6); issue(6); issue(6);
    idle();
    bus.iss_valid = 1'b1; bus.iss_dst = 5'd6;
    at_neg(); chk("sat_stall", DW'(bus.stall), 32'd1); next();
    wback(6, 32'h61); wback(6, 32'h62); wback(6, 32'h63);
    wback(6, 32'h66);
    idle();
    at_neg(); chk("sb_err_set", DW'(bus.sb_err), 32'd1); next();
    at_neg(); chk("sb_err_hold", DW'(bus.sb_err), 32'd1); next();

    // Asynchronous reset in the middle of a cycle
    issue(5);
    wback(5, 32'h0000_ABCD);
    issue(5); issue(6);
    idle();
    bus.rd_addr_a = 5'd5;
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", bus.busy_mask, 32'd0);
    chk("arst_r5", bus.rd_data_a, 32'd5);
    chk("arst_sb_err", DW'(bus.sb_err), 32'd0);
    at_neg();
    next();
    rst = 1'b1;
    bus.iss_valid = 1'b1; bus.iss_use_a = 1'b1; bus.rd_addr_a = 5'd5;
    at_neg(); chk("post_rst_stall", DW'(bus.stall), 32'd0); next();

    // Randomized traffic on a small register window to force collisions
    for (int n = 0; n < 600; n++) begin
      bus.rd_addr_a = 5'($urandom_range(0, 7));
      bus.rd_addr_b = 5'($urandom_range(0, 7));
      bus.iss_valid = 1'($urandom_range(0, 1));
      bus.iss_dst   = 5'($urandom_range(0, 7));
      bus.iss_use_a = 1'($urandom_range(0, 1));
      bus.iss_use_b = 1'($urandom_range(0, 1));
      bus.wr_en     = ($urandom_range(0, 2) != 0);
      bus.wr_addr   = 5'($urandom_range(0, 7));
      bus.wr_data   = $urandom;
      if ($urandom_range(0, 79) == 0) begin
        #2 rst = 1'b0;
        at_neg(); next();
        rst = 1'b1;
      end else begin
        at_neg(); next();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
